// File: rtl/gpr_file.sv
// gpr_file: parametrised register file with two registered, write-bypassed read ports
// and a per-register busy scoreboard for read-after-write hazard detection.
module gpr_file #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  output logic [WIDTH-1:0]      rd_data_a,
  output logic                  rd_valid_a,
  output logic                  rd_busy_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [WIDTH-1:0]      rd_data_b,
  output logic                  rd_valid_b,
  output logic                  rd_busy_b,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [2**ADDR_W-1:0]  busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_wr_ok, w_rsv_ok, w_hit_a, w_hit_b;
  logic [WIDTH-1:0] w_rd_a, w_rd_b;
  // With ZERO_R0 set, register 0 never takes a write, so it reads as 0 even on bypass.
  assign w_wr_ok  = wr_en && !(ZERO_R0 != 0 && wr_addr == '0);
  assign w_rsv_ok = rsv_en && !(ZERO_R0 != 0 && rsv_addr == '0);
  assign w_hit_a  = wr_en && wr_addr == rd_addr_a;
  assign w_hit_b  = wr_en && wr_addr == rd_addr_b;
  assign w_rd_a   = (w_wr_ok && w_hit_a) ? wr_data : r_regs[rd_addr_a];
  assign w_rd_b   = (w_wr_ok && w_hit_b) ? wr_data : r_regs[rd_addr_b];
  assign busy     = r_busy;
  // Reservation is applied after the clear so a same-address reserve wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_en) w_busy_nxt[wr_addr] = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
      rd_busy_a  <= 1'b0;
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
      rd_busy_b  <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[wr_addr] <= wr_data;
      r_busy     <= w_busy_nxt;
      rd_valid_a <= rd_en_a;
      rd_valid_b <= rd_en_b;
      if (rd_en_a) begin
        rd_data_a <= w_rd_a;
        rd_busy_a <= r_busy[rd_addr_a] && !w_hit_a;
      end
      if (rd_en_b) begin
        rd_data_b <= w_rd_b;
        rd_busy_b <= r_busy[rd_addr_b] && !w_hit_b;
      end
    end
  end
endmodule
